dmem_responder: RTL

- Memory-side responder for the single-cycle core's data port. Consumes the core's address (ALUResult), WriteData and MemWrite; returns ReadData in the same cycle.
- Decodes two regions:
  - Word-addressed data RAM.
  - MMIO page holding a console transmit FIFO (ready/valid drain port) and a free-running timer/compare unit producing timer_irq.
- Sits beside the core at top level, in place of a bare RAM.

---
 rtl/dmem_map_pkg.sv | 16 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/dmem_responder.sv | 78 +++++++
 3 files changed

// File: rtl/dmem_map_pkg.sv
// dmem_map_pkg: address map, MMIO offsets, status bit positions and region decode for dmem_responder
package dmem_map_pkg;
  localparam logic [3:0]  RAM_BASE       = 4'h0;
  localparam logic [19:0] MMIO_BASE      = 20'h80000;
  localparam logic [11:0] OFF_CONSOLE_TX = 12'h000;
  localparam logic [11:0] OFF_STATUS     = 12'h004;
  localparam logic [11:0] OFF_TIME       = 12'h008;
  localparam logic [11:0] OFF_TIMECMP    = 12'h00C;
  localparam int STATUS_FULL  = 0;
  localparam int STATUS_EMPTY = 1;
  localparam int STATUS_OVF   = 2;
  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_t;
  function automatic region_t decode_region(input logic [31:0] addr);
    return addr[31:28] == RAM_BASE ? REG_RAM : addr[31:12] == MMIO_BASE ? REG_MMIO : REG_NONE;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular FIFO; ports clk_i, rst_i (async high), push_i/data_i in, pop_i in, full_o/empty_o/head_o out, accept_o = push stored (a full FIFO accepts only alongside a pop)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic             accept_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic pop;
  assign empty_o  = cnt_q == '0;
  assign full_o   = cnt_q == (AW+1)'(DEPTH);
  assign pop      = pop_i && !empty_o;
  assign accept_o = push_i && (!full_o || pop);
  assign head_o   = empty_o ? '0 : mem_q[rd_q];
  always_comb begin
    wr_d  = accept_o ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(accept_o) - (AW+1)'(pop);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (accept_o) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-port responder (RAM + MMIO console FIFO + optional timer via DMEM_MMIO_TIMER_EN); ports clk, reset (async high), Addr/WriteData/MemWrite in, ReadData out, tx_data/tx_valid out, tx_ready in, timer_irq out
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);
  localparam int AW = $clog2(DEPTH_WORDS);
  region_t region;
  logic [11:0] off;
  logic wr_mmio, push, accept, full, empty, ovf_q, ovf_d;
  logic [31:0] ram_q [DEPTH_WORDS];
  logic [31:0] status, time_rd, cmp_rd, mmio_rd;
  assign region  = decode_region(Addr);
  assign off     = Addr[11:0];
  assign wr_mmio = MemWrite && region == REG_MMIO;
  assign push    = wr_mmio && off == OFF_CONSOLE_TX;
  always_ff @(posedge clk) begin
    if (MemWrite && region == REG_RAM) ram_q[Addr[AW+1:2]] <= WriteData;
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk), .rst_i(reset), .push_i(push), .data_i(WriteData[7:0]), .pop_i(tx_ready),
    .full_o(full), .empty_o(empty), .head_o(tx_data), .accept_o(accept)
  );
  assign tx_valid = !empty;
  // a clear and a dropped push cannot coincide: both need this one port in the same cycle
  assign ovf_d = (wr_mmio && off == OFF_STATUS) ? 1'b0 : (push && !accept) ? 1'b1 : ovf_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
  always_comb begin
    status = '0;
    status[STATUS_FULL]  = full;
    status[STATUS_EMPTY] = empty;
    status[STATUS_OVF]   = ovf_q;
  end
`ifdef DMEM_MMIO_TIMER_EN
  logic [31:0] time_q, time_d, cmp_q, cmp_d;
  logic irq_q;
  always_comb begin
    time_d = (wr_mmio && off == OFF_TIME) ? WriteData : time_q + 32'd1;
    cmp_d  = (wr_mmio && off == OFF_TIMECMP) ? WriteData : cmp_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q <= '0;
      cmp_q  <= '1;
      irq_q  <= 1'b0;
    end else begin
      time_q <= time_d;
      cmp_q  <= cmp_d;
      irq_q  <= time_q >= cmp_q;
    end
  end
  assign time_rd   = time_q;
  assign cmp_rd    = cmp_q;
  assign timer_irq = irq_q;
`else
  assign time_rd   = '0;
  assign cmp_rd    = '0;
  assign timer_irq = 1'b0;
`endif
  assign mmio_rd  = (off == OFF_CONSOLE_TX || off == OFF_STATUS) ? status :
                    off == OFF_TIME ? time_rd : off == OFF_TIMECMP ? cmp_rd : '0;
  assign ReadData = region == REG_RAM ? ram_q[Addr[AW+1:2]] : region == REG_MMIO ? mmio_rd : '0;
endmodule
